// File: rtl/screen_reader_scan_ctrl.sv
// Avalon-MM programmable address sequencer for the screen-reader frame-buffer port.
// Optional macro SCAN_IRQ_EN enables the IE bit and the DONE & IE level interrupt.
module screen_reader_scan_ctrl #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned LEN_W  = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_req,
  input  logic              rd_ack,
  output logic              irq
);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] base_w_q, base_w_d;
  logic [LEN_W-1:0]  count_w_q, count_w_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wrap_q, wrap_d;
  logic              done_q, done_d;

`ifdef SCAN_IRQ_EN
  logic              ie_q, ie_d;
`else
  logic              ie_q;
  assign ie_q = 1'b0;
`endif

  logic wr, start, abort, busy, last_idx;
  logic unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign start        = wr && (address == 2'd2) && writedata[0];
  assign abort        = wr && (address == 2'd2) && writedata[1];
  assign busy         = (state_q == StIssue);
  assign last_idx     = (idx_q == count_w_q - LEN_W'(1));
  assign unused_wdata = ^writedata;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    base_w_d  = base_w_q;
    count_w_d = count_w_q;
    idx_d     = idx_q;
    rd_addr_d = rd_addr_q;
    wrap_d    = wrap_q;
    done_d    = done_q;
`ifdef SCAN_IRQ_EN
    ie_d      = ie_q;
`endif

    if (wr) begin
      unique case (address)
        2'd0: base_d = writedata[ADDR_W-1:0];
        2'd1: count_d = writedata[LEN_W-1:0];
        2'd2: begin
          wrap_d = writedata[2];
`ifdef SCAN_IRQ_EN
          ie_d   = writedata[3];
`endif
        end
        2'd3: if (writedata[1]) done_d = 1'b0;
        default: ;
      endcase
    end

    // FSM updates come after register writes so a same-cycle DONE set beats a clear.
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          if (count_q != '0) begin
            base_w_d  = base_q;
            count_w_d = count_q;
            idx_d     = '0;
            rd_addr_d = base_q;
            done_d    = 1'b0;
            state_d   = StIssue;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (abort) begin
          idx_d   = '0;
          state_d = StIdle;
        end else if (rd_ack) begin
          if (!last_idx) begin
            idx_d     = idx_q + LEN_W'(1);
            rd_addr_d = base_w_q + ADDR_W'(idx_q + LEN_W'(1));
          end else if (wrap_q) begin
            idx_d     = '0;
            rd_addr_d = base_w_q;
          end else begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      base_q    <= '0;
      count_q   <= '0;
      base_w_q  <= '0;
      count_w_q <= '0;
      idx_q     <= '0;
      rd_addr_q <= '0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SCAN_IRQ_EN
      ie_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      count_q   <= count_d;
      base_w_q  <= base_w_d;
      count_w_q <= count_w_d;
      idx_q     <= idx_d;
      rd_addr_q <= rd_addr_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
`ifdef SCAN_IRQ_EN
      ie_q      <= ie_d;
`endif
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0: readdata = 32'(base_q);
      2'd1: readdata = 32'(count_q);
      2'd2: readdata = {28'd0, ie_q, wrap_q, 2'b00};
      2'd3: readdata = {20'(idx_q), 10'd0, done_q, busy};
      default: readdata = '0;
    endcase
  end

  assign rd_addr = rd_addr_q;
  assign rd_req  = busy;

`ifdef SCAN_IRQ_EN
  assign irq = done_q & ie_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_screen_reader_scan_ctrl.sv
// Directed self-checking bench for screen_reader_scan_ctrl; inputs change on negedge,
// outputs are checked at negedge (or 1 time unit after, for register reads).
module tb_screen_reader_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [19:0] rd_addr;
  logic        rd_req;
  logic        rd_ack;
  logic        irq;

  int passed = 0;
  int total  = 0;

  screen_reader_scan_ctrl #(.ADDR_W(20), .LEN_W(20)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .rd_addr    (rd_addr),
    .rd_req     (rd_req),
    .rd_ack     (rd_ack),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Called at a negedge; the write is sampled at the following posedge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  logic [31:0] r;
  logic [19:0] exp2 [4];

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; rd_ack = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_rd_req", 32'(rd_req), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_irq", 32'(irq), 0);
    rd(2'd0, r); chk("rst_base", r, 0);
    rd(2'd1, r); chk("rst_count", r, 0);
    rd(2'd2, r); chk("rst_ctrl", r, 0);
    rd(2'd3, r); chk("rst_status", r, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // One-shot scan with continuous ack
    wr(2'd0, 32'h100);
    wr(2'd1, 32'd4);
    rd_ack = 1'b1;
    wr(2'd2, 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("s1_req", 32'(rd_req), 1);
      chk("s1_addr", 32'(rd_addr), 32'h100 + i);
      @(negedge clk);
    end
    chk("s1_end_req", 32'(rd_req), 0);
    rd(2'd3, r); chk("s1_status", r, 32'h2);
    rd_ack = 1'b0;
    @(negedge clk);

    // Address wrap with throttled ack
    exp2[0] = 20'hFFFFE; exp2[1] = 20'hFFFFF; exp2[2] = 20'h00000; exp2[3] = 20'h00001;
    wr(2'd0, 32'hFFFFE);
    wr(2'd1, 32'd4);
    wr(2'd2, 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("s2_addr", 32'(rd_addr), 32'(exp2[i]));
      if (i == 2) begin
        rd(2'd3, r); chk("s2_status_mid", r, 32'h2001);
      end
      @(negedge clk);
      chk("s2_hold_req", 32'(rd_req), 1);
      chk("s2_hold_addr", 32'(rd_addr), 32'(exp2[i]));
      rd_ack = 1'b1;
      @(negedge clk);
      rd_ack = 1'b0;
    end
    chk("s2_end_req", 32'(rd_req), 0);
    rd(2'd3, r); chk("s2_status", r, 32'h2);
    @(negedge clk);

    // Continuous wrap scan, then abort
    wr(2'd0, 32'h10);
    wr(2'd1, 32'd3);
    rd_ack = 1'b1;
    wr(2'd2, 32'h5);
    for (int i = 0; i < 7; i++) begin
      chk("s3_addr", 32'(rd_addr), 32'h10 + (i % 3));
      @(negedge clk);
    end
    chk("s3_req_pre_abort", 32'(rd_req), 1);
    wr(2'd2, 32'h6);
    chk("s3_abort_req", 32'(rd_req), 0);
    rd(2'd3, r); chk("s3_abort_status", r, 32'h0);
    rd(2'd2, r); chk("s3_ctrl_wrap", r, 32'h4);
    @(negedge clk);
    wr(2'd2, 32'h0);
    rd_ack = 1'b0;

    // COUNT=0 start, then START+ABORT together
    wr(2'd1, 32'd0);
    wr(2'd2, 32'h1);
    chk("s4_zero_req", 32'(rd_req), 0);
    @(negedge clk);
    chk("s4_zero_req2", 32'(rd_req), 0);
    rd(2'd3, r); chk("s4_zero_status", r, 32'h2);
    @(negedge clk);
    wr(2'd1, 32'd5);
    wr(2'd2, 32'h3);
    chk("s4_sa_req", 32'(rd_req), 0);
    rd(2'd3, r); chk("s4_sa_status", r, 32'h2);
    @(negedge clk);
    wr(2'd3, 32'h2);
    rd(2'd3, r); chk("s4_done_clr", r, 32'h0);
    @(negedge clk);

    // BASE write and START during an active scan
    wr(2'd0, 32'h100);
    wr(2'd1, 32'd8);
    rd_ack = 1'b1;
    wr(2'd2, 32'h1);
    chk("s5_addr0", 32'(rd_addr), 32'h100);
    wr(2'd0, 32'h200);
    chk("s5_addr1", 32'(rd_addr), 32'h101);
    wr(2'd2, 32'h1);
    for (int i = 2; i < 8; i++) begin
      chk("s5_addr", 32'(rd_addr), 32'h100 + i);
      @(negedge clk);
    end
    chk("s5_end_req", 32'(rd_req), 0);
    rd(2'd0, r); chk("s5_base", r, 32'h200);
    @(negedge clk);
    wr(2'd2, 32'h1);
    chk("s5_restart_addr", 32'(rd_addr), 32'h200);
    chk("s5_restart_req", 32'(rd_req), 1);

    // Reset mid-scan
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("s6_req", 32'(rd_req), 0);
    chk("s6_addr", 32'(rd_addr), 0);
    rd(2'd0, r); chk("s6_base", r, 0);
    rd(2'd3, r); chk("s6_status", r, 0);
    rd_ack = 1'b0;
    @(negedge clk);

    // Interrupt
    wr(2'd2, 32'h9);
`ifdef SCAN_IRQ_EN
    chk("s7_irq_set", 32'(irq), 1);
    rd(2'd2, r); chk("s7_ctrl_ie", r, 32'h8);
`else
    chk("s7_irq_set", 32'(irq), 0);
    rd(2'd2, r); chk("s7_ctrl_ie", r, 32'h0);
`endif
    rd(2'd3, r); chk("s7_status", r, 32'h2);
    @(negedge clk);
    wr(2'd3, 32'h2);
    chk("s7_irq_clr", 32'(irq), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
